// File: rtl/fire_seq_pkg.sv
// Shared types and default parameters for the fire layer sequencer.
// Holds the FSM state enum and default-parameter localparams.
package fire_seq_pkg;

    localparam int DEF_N_LAYERS = 3;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_ACK,
        ST_DONE,
        ST_ERR
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Progress watchdog: counts enabled cycles since the last clear.
// Ports: clk, rst (async active-low), clear, enable in; expired out.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    // cnt holds the number of earlier enabled cycles, so the
    // TIMEOUT_CYCLES-th enabled cycle without progress expires.
    assign expired = enable && !clear &&
                     (cnt >= W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fire_layer_sequencer.sv
// Sequences layer blocks 0..N_LAYERS-1: enable, count samples, acknowledge.
// Ports: clk, rst (async active-low), start, layer_finish, layer_sample in;
//        layer_en, ram_feedback, cur_layer, sample_count, busy, done, error out.
// Optional watchdog: define SEQ_TIMEOUT_EN to enable the RUN-state timeout.
module fire_layer_sequencer
    import fire_seq_pkg::*;
#(
    parameter int N_LAYERS = DEF_N_LAYERS,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_LAYERS-1:0] layer_finish,
    input  logic [N_LAYERS-1:0] layer_sample,
    output logic [N_LAYERS-1:0] layer_en,
    output logic [N_LAYERS-1:0] ram_feedback,
    output logic [LW-1:0]       cur_layer,
    output logic [CNT_W-1:0]    sample_count,
    output logic                busy,
    output logic                done,
    output logic                error
);

    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t state, state_n;
    logic [LW-1:0] cur_n;
    logic [CNT_W-1:0] cnt_n;
    logic [N_LAYERS-1:0] sel;
    logic last_layer;
    logic cur_sample;
    logic cur_finish;
    logic wd_expired;

    assign sel = N_LAYERS'(1) << cur_layer;
    assign last_layer = (cur_layer == LW'(N_LAYERS - 1));
    assign cur_sample = layer_sample[cur_layer];
    assign cur_finish = layer_finish[cur_layer];

`ifdef SEQ_TIMEOUT_EN
    // Cleared outside RUN so every RUN entry starts from zero.
    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state != ST_RUN) || cur_sample),
        .enable (state == ST_RUN),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cur_layer <= '0;
            sample_count <= '0;
        end else begin
            state <= state_n;
            cur_layer <= cur_n;
            sample_count <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_n = cur_layer;
        cnt_n = sample_count;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    cur_n = '0;
                    cnt_n = '0;
                end
            end
            ST_RUN: begin
                if (cur_sample && (sample_count != '1)) begin
                    cnt_n = sample_count + 1'b1;
                end
                // A finish in the same cycle as expiry still counts as progress.
                if (cur_finish) begin
                    state_n = ST_ACK;
                end else if (wd_expired) begin
                    state_n = ST_ERR;
                end
            end
            ST_ACK: begin
                if (last_layer) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                    cur_n = cur_layer + 1'b1;
                    cnt_n = '0;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            ST_ERR: state_n = ST_ERR;
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state so reset clears them at once.
    assign layer_en = (state == ST_RUN) ? sel : '0;
    assign ram_feedback = (state == ST_ACK) ? sel : '0;
    assign busy = (state == ST_RUN) || (state == ST_ACK);
    assign done = (state == ST_DONE);
    assign error = (state == ST_ERR);

endmodule
